// File: rtl/anode_scan_controller_pkg.sv
// Shared constants and types for the four-digit common-anode scan controller.
package anode_scan_controller_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    // Anodes are active-low: all ones means every digit is dark.
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    // One-cold anode drive for digits 0..3.
    localparam logic [NUM_DIGITS-1:0] ANODE_ONE_COLD [NUM_DIGITS] = '{
        4'b1110,
        4'b1101,
        4'b1011,
        4'b0111
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    // Anode pattern for a digit slot: lit digits pull their anode low,
    // masked digits keep the whole display dark for the same duration.
    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [IDX_W-1:0] idx,
                                                        input logic             lit);
        return lit ? ANODE_ONE_COLD[idx] : ANODE_OFF;
    endfunction

endpackage

// File: rtl/scan_slot_counter.sv
// Free-running slot timer: counts 0..PRESCALE-1 and flags the last cycle of a slot.
module scan_slot_counter #(
    parameter  int unsigned PRESCALE = 8,
    localparam int unsigned CNT_W    = $clog2(PRESCALE)
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iClear,
    input  logic             iCount,
    output logic [CNT_W-1:0] ovCount,
    output logic             oTerminal
);

    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign oTerminal = (count_q == COUNT_LAST);
    assign ovCount   = count_q;

    // Next count: clear wins, otherwise advance and wrap at the slot end.
    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned,
        // which would otherwise infer a latch.
        count_d = count_q;
        if (iClear) begin
            count_d = '0;
        end else if (iCount) begin
            count_d = oTerminal ? '0 : count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge iClk or negedge iReset_n) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples the pre-edge values regardless of statement order.
        if (!iReset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/anode_scan_controller.sv
// Four-digit anode multiplexer: blanked slot rotation with a one-cycle segment load strobe.
module anode_scan_controller
    import anode_scan_controller_pkg::*;
#(
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                  iClk,
    input  logic                  iReset_n,
    input  logic                  iEnable,
    input  logic [NUM_DIGITS-1:0] ivDigitMask,
    output logic [NUM_DIGITS-1:0] ovAnode,
    output logic                  oCE,
    output logic [IDX_W-1:0]      ovDigitIdx,
    output logic                  oFrameDone
);

    localparam int unsigned      CNT_W      = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);

    // A slot needs at least one dark cycle to stop ghosting and at least two
    // show cycles so the load strobe never lands on the final cycle.
    if (PRESCALE < 4 || PRESCALE > (1 << 20) ||
        BLANK_CYCLES < 1 || BLANK_CYCLES >= PRESCALE - 1) begin : g_bad_params
        $fatal(1, "anode_scan_controller: illegal PRESCALE=%0d / BLANK_CYCLES=%0d",
               PRESCALE, BLANK_CYCLES);
    end

    scan_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  ce_q, ce_d;
    logic                  frame_done_q, frame_done_d;

    logic [CNT_W-1:0]      slot_count;
    logic                  slot_last;
    logic                  slot_clear;
    logic                  slot_run;

    // The counter sits at zero whenever the scan is idle or being shut down,
    // so every restart begins a fresh BLANK at count 0.
    assign slot_clear = !iEnable || (state_q == ST_IDLE);
    assign slot_run   = (state_q != ST_IDLE);

    scan_slot_counter #(
        .PRESCALE (PRESCALE)
    ) u_slot_counter (
        .iClk      (iClk),
        .iReset_n  (iReset_n),
        .iClear    (slot_clear),
        .iCount    (slot_run),
        .ovCount   (slot_count),
        .oTerminal (slot_last)
    );

    // Next-state and next-output decode for the scan FSM.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        anode_d      = anode_q;
        ce_d         = 1'b0;
        frame_done_d = 1'b0;

        if (!iEnable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            anode_d = ANODE_OFF;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    anode_d = ANODE_OFF;
                end
                ST_BLANK: begin
                    anode_d = ANODE_OFF;
                    if (slot_count == BLANK_LAST) begin
                        // Mask bit is frozen here so mid-slot changes wait for the next slot.
                        state_d = ST_SHOW;
                        ce_d    = 1'b1;
                        anode_d = anode_for(idx_q, ivDigitMask[idx_q]);
                    end
                end
                ST_SHOW: begin
                    if (slot_last) begin
                        state_d      = ST_BLANK;
                        anode_d      = ANODE_OFF;
                        idx_d        = idx_q + IDX_W'(1);
                        frame_done_d = (idx_q == LAST_DIGIT);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    anode_d = ANODE_OFF;
                end
            endcase
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            anode_q      <= ANODE_OFF;
            ce_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            anode_q      <= anode_d;
            ce_q         <= ce_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ovAnode    = anode_q;
    assign oCE        = ce_q;
    assign ovDigitIdx = idx_q;
    assign oFrameDone = frame_done_q;

endmodule

// File: tb/tb_anode_scan_controller.sv
// Bench for anode_scan_controller with PRESCALE=8, BLANK_CYCLES=2.
module tb_anode_scan_controller;

    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = 4 * P;

    logic       iClk        = 1'b0;
    logic       iReset_n    = 1'b0;
    logic       iEnable     = 1'b0;
    logic [3:0] ivDigitMask = 4'hF;
    logic [3:0] ovAnode;
    logic       oCE;
    logic [1:0] ovDigitIdx;
    logic       oFrameDone;

    int errors = 0;
    int checks = 0;

    anode_scan_controller #(
        .PRESCALE     (P),
        .BLANK_CYCLES (B)
    ) dut (
        .iClk        (iClk),
        .iReset_n    (iReset_n),
        .iEnable     (iEnable),
        .ivDigitMask (ivDigitMask),
        .ovAnode     (ovAnode),
        .oCE         (oCE),
        .ovDigitIdx  (ovDigitIdx),
        .oFrameDone  (oFrameDone)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [3:0] anode;
        logic       ce;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: position within the frame since the scan was (re)started.
    bit m_on  = 1'b0;
    int m_t   = 0;
    bit m_lit = 1'b0;

    always @(posedge iClk) begin
        exp_t e;
        int   pos;
        int   dig;
        e = '{anode: 4'hF, ce: 1'b0, idx: 2'd0, fd: 1'b0};
        if (!iReset_n || !iEnable) begin
            m_on  = 1'b0;
            m_t   = 0;
            m_lit = 1'b0;
        end else if (!m_on) begin
            m_on  = 1'b1;
            m_t   = 0;
            m_lit = 1'b0;
        end else begin
            m_t = (m_t + 1) % FRAME;
            pos = m_t % P;
            dig = m_t / P;
            if (pos == B) m_lit = ivDigitMask[dig];
            e.anode = (pos >= B && m_lit) ? 4'(~(4'b0001 << dig)) : 4'hF;
            e.ce    = (pos == B);
            e.idx   = 2'(dig);
            e.fd    = (m_t == 0);
        end
        sb_q.push_back(e);
    end

    // Scoreboard comparison, away from the active edge.
    always @(negedge iClk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if ({ovAnode, oCE, ovDigitIdx, oFrameDone} !== e) begin
                errors++;
                $display("FAIL scoreboard @%0t: got anode=%b ce=%b idx=%0d fd=%b, want anode=%b ce=%b idx=%0d fd=%b",
                         $time, ovAnode, oCE, ovDigitIdx, oFrameDone, e.anode, e.ce, e.idx, e.fd);
            end
        end
    end

    // Restart the scan with the given mask; the next negedge observes scan cycle 0.
    task automatic start_scan(input logic [3:0] mask);
        @(negedge iClk);
        iEnable     = 1'b0;
        ivDigitMask = mask;
        @(negedge iClk);
        @(negedge iClk);
        iEnable = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge iClk);
        checks++;
        if (ovAnode !== 4'hF) begin errors++; $display("FAIL reset_anode: got %b want 1111", ovAnode); end
        checks++;
        if (oCE !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b want 0", oCE); end
        checks++;
        if (ovDigitIdx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", ovDigitIdx); end
        checks++;
        if (oFrameDone !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", oFrameDone); end
        iReset_n = 1'b1;
    endtask

    task automatic test_full_mask();
        logic [3:0] pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] exp_anode;
        int ce_cnt = 0;
        int fd_at  = -1;
        start_scan(4'hF);
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge iClk);
            exp_anode = ((c % P) < B) ? 4'hF : pat[(c / P) % 4];
            checks++;
            if (ovAnode !== exp_anode) begin
                errors++;
                $display("FAIL full_mask_anode c=%0d: got %b want %b", c, ovAnode, exp_anode);
            end
            if (oCE === 1'b1) begin
                ce_cnt++;
                checks++;
                if ((c % P) != B) begin errors++; $display("FAIL full_mask_ce_pos c=%0d: got strobe, want only at slot offset %0d", c, B); end
            end
            if (oFrameDone === 1'b1 && fd_at < 0) fd_at = c;
        end
        checks++;
        if (ce_cnt != 8) begin errors++; $display("FAIL full_mask_ce_count: got %0d want 8", ce_cnt); end
        checks++;
        if (fd_at != FRAME) begin errors++; $display("FAIL full_mask_frame_done: got cycle %0d want %0d", fd_at, FRAME); end
    endtask

    task automatic test_partial_mask();
        int ce_cnt = 0;
        int lit1   = 0;
        int lit3   = 0;
        int bad    = 0;
        start_scan(4'b1010);
        for (int c = 0; c < FRAME; c++) begin
            @(negedge iClk);
            if (oCE === 1'b1) ce_cnt++;
            if (ovAnode === 4'b1101 && c >= 10 && c < 16) lit1++;
            else if (ovAnode === 4'b0111 && c >= 26 && c < 32) lit3++;
            else if (ovAnode !== 4'hF) bad++;
        end
        checks++;
        if (ce_cnt != 4) begin errors++; $display("FAIL partial_ce_count: got %0d want 4", ce_cnt); end
        checks++;
        if (lit1 != 6) begin errors++; $display("FAIL partial_digit1_cycles: got %0d want 6", lit1); end
        checks++;
        if (lit3 != 6) begin errors++; $display("FAIL partial_digit3_cycles: got %0d want 6", lit3); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL partial_masked_digits: got %0d unexpected lit cycles want 0", bad); end
    endtask

    task automatic test_mask_change();
        int lit1   = 0;
        int bad    = 0;
        int ce_cnt = 0;
        start_scan(4'hF);
        repeat (12) @(negedge iClk);
        checks++;
        if (ovAnode !== 4'b1101) begin errors++; $display("FAIL mask_change_pre: got %b want 1101", ovAnode); end
        ivDigitMask = 4'h0;
        for (int c = 12; c < 2 * FRAME; c++) begin
            @(negedge iClk);
            if (c < 16 && ovAnode === 4'b1101) lit1++;
            if (c >= 16 && ovAnode !== 4'hF) bad++;
            if (c >= 16 && c < 48 && oCE === 1'b1) ce_cnt++;
        end
        checks++;
        if (lit1 != 4) begin errors++; $display("FAIL mask_change_hold: got %0d lit cycles want 4", lit1); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mask_change_dark: got %0d lit cycles want 0", bad); end
        checks++;
        if (ce_cnt != 4) begin errors++; $display("FAIL mask_change_ce: got %0d want 4", ce_cnt); end
    endtask

    task automatic test_enable_drop();
        start_scan(4'hF);
        repeat (21) @(negedge iClk);
        checks++;
        if (ovAnode !== 4'b1011) begin errors++; $display("FAIL enable_drop_pre: got %b want 1011", ovAnode); end
        iEnable = 1'b0;
        @(negedge iClk);
        checks++;
        if (ovAnode !== 4'hF) begin errors++; $display("FAIL enable_drop_anode: got %b want 1111", ovAnode); end
        checks++;
        if (ovDigitIdx !== 2'd0) begin errors++; $display("FAIL enable_drop_idx: got %0d want 0", ovDigitIdx); end
        iEnable = 1'b1;
        repeat (2) begin
            @(negedge iClk);
            checks++;
            if (ovAnode !== 4'hF) begin errors++; $display("FAIL reenable_blank: got %b want 1111", ovAnode); end
        end
        @(negedge iClk);
        checks++;
        if ({ovAnode, oCE} !== {4'b1110, 1'b1}) begin
            errors++;
            $display("FAIL reenable_show: got anode=%b ce=%b want anode=1110 ce=1", ovAnode, oCE);
        end
    endtask

    task automatic test_async_reset();
        start_scan(4'hF);
        repeat (3) @(negedge iClk);
        checks++;
        if ({ovAnode, oCE} !== {4'b1110, 1'b1}) begin
            errors++;
            $display("FAIL async_pre: got anode=%b ce=%b want anode=1110 ce=1", ovAnode, oCE);
        end
        #2 iReset_n = 1'b0;
        #1;
        checks++;
        if ({ovAnode, oCE} !== {4'hF, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_immediate: got anode=%b ce=%b want anode=1111 ce=0", ovAnode, oCE);
        end
        @(negedge iClk);
        iReset_n = 1'b1;
        repeat (3) @(negedge iClk);
        checks++;
        if ({ovAnode, oCE, ovDigitIdx} !== {4'b1110, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL async_resume: got anode=%b ce=%b idx=%0d want anode=1110 ce=1 idx=0",
                     ovAnode, oCE, ovDigitIdx);
        end
    endtask

    task automatic test_random();
        logic [3:0] prev = 4'hF;
        int dark = 0;
        start_scan(4'hF);
        for (int c = 0; c < 1000 * FRAME; c++) begin
            @(negedge iClk);
            checks++;
            if ($countones(~ovAnode) > 1) begin
                errors++;
                $display("FAIL random_one_cold c=%0d: got %b want at most one low bit", c, ovAnode);
            end
            checks++;
            if (prev !== 4'hF && ovAnode !== 4'hF && ovAnode !== prev) begin
                errors++;
                $display("FAIL random_ghost c=%0d: got %b after %b want a dark cycle between digits", c, ovAnode, prev);
            end
            prev = ovAnode;
            if (dark > 0) begin
                dark--;
                if (dark == 0) iEnable = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                iEnable = 1'b0;
                dark    = $urandom_range(1, 3);
            end
            if ($urandom_range(0, 15) == 0) ivDigitMask = 4'($urandom_range(0, 15));
        end
        iEnable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_partial_mask();
        test_mask_change();
        test_enable_drop();
        test_async_reset();
        test_random();
        repeat (2) @(negedge iClk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
